n101_icb2sram_ctrl: RTL and testbench

//  ICB-slave front end for the single-port synchronous sim/SRAM macro (1-cycle registered read).

---
 rtl/n101_icb2sram_ctrl.sv | 138 +++++++++++++
 tb/tb_n101_icb2sram_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_icb2sram_ctrl.sv
// ---------------------------------------------------------------------------
// n101_icb2sram_ctrl
//   ICB slave front end for a single-port synchronous SRAM with a 1-cycle
//   registered read. Accepted commands drive the RAM strobes combinationally.
//   Read data is captured the cycle after issue and queued in a small response
//   FIFO. A command is accepted only when a FIFO slot is reserved for it, so
//   response backpressure never drops RAM data.
//
//   Optional feature macro: N101_ICB2SRAM_ERR_EN
//     When it is defined, addresses outside [BASE_ADDR, BASE_ADDR + 4*2**RAM_AW)
//     are accepted without touching the RAM, and they respond with err=1 and
//     rdata=0. When it is undefined, upper address bits alias into the RAM and
//     o_icb_rsp_err is tied to 0.
//
// Ports
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_icb_cmd_valid/o_icb_cmd_ready  command handshake
//   i_icb_cmd_addr/read/wdata/wmask  command payload (addr[1:0] ignored)
//   o_icb_rsp_valid/i_icb_rsp_ready  response handshake
//   o_icb_rsp_rdata/o_icb_rsp_err    response payload
//   o_ram_cs/we/wem/addr/din         RAM strobes, all zero when nothing is issued
//   i_ram_dout                       RAM read data, valid the cycle after cs
// ---------------------------------------------------------------------------
module n101_icb2sram_ctrl #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            MW        = 4,
  parameter int            RAM_AW    = 9,
  parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int            RSP_DEPTH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_icb_cmd_valid,
  output logic              o_icb_cmd_ready,
  input  logic [AW-1:0]     i_icb_cmd_addr,
  input  logic              i_icb_cmd_read,
  input  logic [DW-1:0]     i_icb_cmd_wdata,
  input  logic [MW-1:0]     i_icb_cmd_wmask,
  output logic              o_icb_rsp_valid,
  input  logic              i_icb_rsp_ready,
  output logic [DW-1:0]     o_icb_rsp_rdata,
  output logic              o_icb_rsp_err,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [MW-1:0]     o_ram_wem,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DW-1:0]     o_ram_din,
  input  logic [DW-1:0]     i_ram_dout
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic              r_inflight;
  logic              r_rd;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [DW-1:0]     r_rdata_mem [RSP_DEPTH];

  logic              w_acc, w_cs, w_oor, w_push, w_pop;
  logic [CW-1:0]     w_occ;
  logic [RAM_AW-1:0] w_word;
  logic [DW-1:0]     w_push_rdata;

  // The in-flight access counts as occupied, so its data always has a slot.
  assign w_occ           = r_cnt + CW'(r_inflight);
  assign o_icb_cmd_ready = ~i_rst & (w_occ < DEPTH_C);
  assign w_acc           = i_icb_cmd_valid & o_icb_cmd_ready;
  assign w_word          = RAM_AW'((i_icb_cmd_addr - BASE_ADDR) >> 2);

`ifdef N101_ICB2SRAM_ERR_EN
  localparam logic [AW:0] LIMIT = {1'b0, BASE_ADDR} + ((AW+1)'(1) << (RAM_AW + 2));
  logic r_oor;
  logic r_err_mem [RSP_DEPTH];
  // The compare is done one bit wider so that the upper limit cannot wrap.
  assign w_oor = ({1'b0, i_icb_cmd_addr} < {1'b0, BASE_ADDR}) |
                 ({1'b0, i_icb_cmd_addr} >= LIMIT);
  assign w_push_rdata = (r_rd & ~r_oor) ? i_ram_dout : '0;
  assign o_icb_rsp_err = r_err_mem[r_rptr];
  always_ff @(posedge i_clk) begin
    if (i_rst) r_oor <= 1'b0;
    else       r_oor <= w_oor;
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_err_mem[r_wptr] <= r_oor;
  end
`else
  assign w_oor         = 1'b0;
  assign w_push_rdata  = r_rd ? i_ram_dout : '0;
  assign o_icb_rsp_err = 1'b0;
`endif

  assign w_cs       = w_acc & ~w_oor;
  assign o_ram_cs   = w_cs;
  assign o_ram_we   = w_cs & ~i_icb_cmd_read;
  assign o_ram_wem  = (w_cs & ~i_icb_cmd_read) ? i_icb_cmd_wmask : '0;
  assign o_ram_addr = w_cs ? w_word : '0;
  assign o_ram_din  = w_cs ? i_icb_cmd_wdata : '0;

  assign w_push          = r_inflight;
  assign o_icb_rsp_valid = (r_cnt != '0);
  assign w_pop           = o_icb_rsp_valid & i_icb_rsp_ready;
  assign o_icb_rsp_rdata = r_rdata_mem[r_rptr];

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
      r_rd       <= 1'b0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= w_acc;
      r_rd       <= i_icb_cmd_read;
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The payload storage has no reset. Because the pointers and the count are
  // reset, stale entries are never presented.
  always_ff @(posedge i_clk) begin
    if (w_push) r_rdata_mem[r_wptr] <= w_push_rdata;
  end

endmodule

// File: tb/tb_n101_icb2sram_ctrl.sv
module tb_n101_icb2sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_cs, ram_we;
  logic [3:0]  ram_wem;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  n101_icb2sram_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .o_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
    .o_icb_rsp_rdata(rsp_rdata), .o_icb_rsp_err(rsp_err),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_wem(ram_wem),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with a registered read.
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= ram[ram_addr];
      end
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t        exp_q[$];
  int          pop_q[$];
  logic [31:0] ref_mem [int];
  int          nassert = 0, nfail = 0;
  int          cyc = 0, acc_cnt = 0, last_lat = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor and scoreboard. Sampling happens 2 time units after the falling
  // edge, when the inputs for this cycle are stable.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, prev_rdata);
        chk("hold_err", rsp_err, prev_err);
      end
      if (rsp_valid && rsp_ready) begin
        nassert++;
        assert (exp_q.size() != 0) else begin
          nfail++;
          $error("FAIL unexpected_rsp: observed rdata %h, expected no response", rsp_rdata);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          last_lat = cyc - e.cyc;
          chk("lat_min2", last_lat >= 2, 1);
        end
        pop_q.push_back(cyc);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
      if (cmd_valid && cmd_ready) begin
        exp_t        e;
        logic [31:0] off, cur;
        logic [8:0]  widx;
        logic        oor;
        off  = cmd_addr - 32'h8000_0000;
        widx = off[10:2];
`ifdef N101_ICB2SRAM_ERR_EN
        oor = (cmd_addr < 32'h8000_0000) || (cmd_addr >= 32'h8000_0800);
`else
        oor = 1'b0;
`endif
        cur = ref_mem.exists(int'(widx)) ? ref_mem[int'(widx)] : 32'h0;
        chk("ram_cs", ram_cs, !oor);
        if (!oor) begin
          chk("ram_we", ram_we, !cmd_read);
          chk("ram_wem", ram_wem, cmd_read ? 4'h0 : cmd_wmask);
          chk("ram_addr", ram_addr, widx);
          chk("ram_din", ram_din, cmd_wdata);
        end
        e.rdata = (cmd_read && !oor) ? cur : 32'h0;
        e.err   = oor;
        e.cyc   = cyc;
        exp_q.push_back(e);
        if (!cmd_read && !oor) begin
          for (int b = 0; b < 4; b++)
            if (cmd_wmask[b]) cur[8*b +: 8] = cmd_wdata[8*b +: 8];
          ref_mem[int'(widx)] = cur;
        end
        acc_cnt++;
      end else begin
        chk("idle_ram_cs", ram_cs, 0);
      end
      prev_hold  = rsp_valid & ~rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
    end
  end

  task automatic issue(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                       input logic [3:0] m, output logic rdy0);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_wmask = m;
    #1;
    rdy0 = cmd_ready;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("accept_timeout", n < 50, 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic r;
    int   base;
    rst = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h8000_0000; cmd_read = 1'b0;
    cmd_wdata = 32'h0BAD_0BAD; cmd_wmask = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ram_cs", ram_cs, 0);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", cmd_ready, 1);

    // Full-word write, then a read of the same word, with latency N+2.
    issue(32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, r);
    idle(); drain();
    chk("wr_lat", last_lat, 2);
    issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, r);
    idle(); drain();
    chk("rd_lat", last_lat, 2);
    chk("rd_deadbeef", last_rdata, 32'hDEAD_BEEF);
    chk("rd_err0", last_err, 0);

    // Partial write mask, followed by a write with wmask 0 that must change no byte.
    issue(32'h8000_0020, 1'b0, 32'hFFFF_FFFF, 4'hF, r);
    issue(32'h8000_0020, 1'b0, 32'h1122_3344, 4'b0101, r);
    issue(32'h8000_0020, 1'b0, 32'h0000_0000, 4'h0, r);
    issue(32'h8000_0020, 1'b1, 32'h0, 4'h0, r);
    idle(); drain();
    chk("partial_mask", last_rdata, 32'hFF22_FF44);

    // Back-to-back writes of words 0..7, then back-to-back reads.
    for (int i = 0; i < 8; i++) issue(32'h8000_0000 + 4*i, 1'b0, 32'h1000_0000 + i, 4'hF, r);
    idle(); drain();
    pop_q.delete();
    for (int i = 0; i < 8; i++) begin
      issue(32'h8000_0000 + 4*i, 1'b1, 32'h0, 4'h0, r);
      chk("b2b_ready", r, 1);
    end
    idle(); drain();
    chk("b2b_rsp_cnt", pop_q.size(), 8);
    if (pop_q.size() == 8) chk("b2b_rsp_span", pop_q[7] - pop_q[0], 7);

    // Backpressure: exactly 3 commands are accepted, then cmd_ready drops.
    rsp_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 3; i++) issue(32'h8000_0000 + 4*i, 1'b1, 32'h0, 4'h0, r);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h8000_000C; cmd_read = 1'b1;
    repeat (4) begin #1; chk("bp_not_ready", cmd_ready, 0); @(negedge clk); end
    chk("bp_accepted", acc_cnt - base, 3);
    chk("bp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    issue(32'h8000_000C, 1'b1, 32'h0, 4'h0, r);
    idle(); drain();

    // Reset with 2 responses queued and 1 read in flight, plus a write
    // presented during the reset cycle that must not reach the RAM.
    issue(32'h8000_00C0, 1'b0, 32'hA5A5_A5A5, 4'hF, r);
    idle(); drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h8000_0000 + 4*i, 1'b1, 32'h0, 4'h0, r);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h8000_00C0; cmd_read = 1'b0;
    cmd_wdata = 32'h5A5A_5A5A; cmd_wmask = 4'hF;
    #1;
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_cs", ram_cs, 0);
    @(negedge clk);
    cmd_valid = 1'b0; rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready_after", cmd_ready, 1);
    rsp_ready = 1'b1;
    issue(32'h8000_00C0, 1'b1, 32'h0, 4'h0, r);
    idle(); drain();
    chk("rst_write_blocked", last_rdata, 32'hA5A5_A5A5);

    // Out-of-window address.
    issue(32'h9000_0000, 1'b1, 32'h0, 4'h0, r);
    idle(); drain();
`ifdef N101_ICB2SRAM_ERR_EN
    chk("oor_rdata", last_rdata, 32'h0);
    chk("oor_err", last_err, 1);
`else
    chk("alias_rdata", last_rdata, 32'h1000_0000);
    chk("alias_err", last_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
